uart_grid_bridge: RTL and testbench

UART_GRID_BRIDGE -- requirements
Module: uart_grid_bridge

---
 rtl/uart_grid_bridge.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_uart_grid_bridge.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_grid_bridge.sv
// uart_grid_bridge
//   Byte-command bridge between a UART-style byte stream and a row-organised
//   cell grid (e.g. a Life engine). Commands received on rx:
//     '0'-'9'  accumulate a decimal repeat count (echoed, saturating)
//     's'      pulse grid_step max(count,1) times, then send 'S'
//     'r'      dump every row as '#'/'.' characters, one line per row
//     'R'      one grid_step pulse, then dump
//     'w'      rewind the write cursor to row 0 / column 0, send 'W'
//     '.' '#'  write one cell at the cursor (echoed); a full row is committed
//     'c'      clear every row, then send 'C'
//     other    answered with 'X'
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rx_data/rx_valid  incoming byte; rx_ready high when the byte is taken
//   tx_data/tx_valid  outgoing byte; held until tx_ready completes it
//   grid_row_sel      row address for both read and write
//   grid_step         one-generation pulse
//   grid_wr_en        row write strobe with grid_wr_data
//   grid_rd_data      row contents, valid one cycle after grid_row_sel moves
//   busy              high whenever the command engine is not idle
//
// Build option
//   GRID_BRIDGE_CRLF_EN  line ends become CR LF and every dump starts with
//                        CR LF; otherwise a bare LF ends each line.
module uart_grid_bridge #(
    parameter int COLS       = 8,
    parameter int ROWS       = 32,
    parameter int MAX_REPEAT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [$clog2(ROWS)-1:0]  grid_row_sel,
    output logic                     grid_step,
    output logic                     grid_wr_en,
    output logic [COLS-1:0]          grid_wr_data,
    input  logic [COLS-1:0]          grid_rd_data,
    output logic                     busy
);

    localparam int RB = $clog2(ROWS);
    localparam int CB = $clog2(COLS);
    localparam logic [RB-1:0] LAST_ROW = RB'(ROWS - 1);
    localparam logic [CB-1:0] LAST_COL = CB'(COLS - 1);
    localparam logic [20:0]   MAX_ACC  = 21'(MAX_REPEAT);
    localparam logic [15:0]   MAX_CNT  = 16'(MAX_REPEAT);

    typedef enum logic [2:0] {
        IDLE, STEP, DUMP_WAIT, DUMP_COL, DUMP_EOL, CLEAR, ECHO
    } state_t;

    state_t          state, state_n;
    logic [7:0]      tx_data_n;
    logic            tx_valid_n;
    logic [15:0]     count, count_n;
    logic [15:0]     rep, rep_n;
    logic [CB-1:0]   dcol, dcol_n;
    logic [CB-1:0]   wcol, wcol_n;
    logic [RB-1:0]   row, row_n, next_row;
    logic [COLS-1:0] wdata, wdata_n;
    logic            wr_pulse, wr_pulse_n;
    logic            eol_hi, eol_hi_n;
    logic            lead, lead_n;
    logic            dump_after, dump_after_n;
    logic [7:0]      resp, resp_n;

    logic            tx_free;
    logic            send;
    logic [7:0]      send_byte;
    logic            start_dump;
    logic            line_done;
    logic [20:0]     acc;

    assign tx_free      = !tx_valid || tx_ready;
    assign rx_ready     = (state == IDLE) && !tx_valid;
    assign busy         = (state != IDLE);
    assign grid_step    = (state == STEP);
    assign grid_wr_en   = wr_pulse || (state == CLEAR);
    assign grid_wr_data = wdata;
    assign grid_row_sel = row;
    assign next_row     = (row == LAST_ROW) ? '0 : row + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            count      <= '0;
            rep        <= '0;
            dcol       <= '0;
            wcol       <= '0;
            row        <= '0;
            wdata      <= '0;
            wr_pulse   <= 1'b0;
            eol_hi     <= 1'b0;
            lead       <= 1'b0;
            dump_after <= 1'b0;
            resp       <= '0;
        end else begin
            state      <= state_n;
            tx_data    <= tx_data_n;
            tx_valid   <= tx_valid_n;
            count      <= count_n;
            rep        <= rep_n;
            dcol       <= dcol_n;
            wcol       <= wcol_n;
            row        <= row_n;
            wdata      <= wdata_n;
            wr_pulse   <= wr_pulse_n;
            eol_hi     <= eol_hi_n;
            lead       <= lead_n;
            dump_after <= dump_after_n;
            resp       <= resp_n;
        end
    end

    always_comb begin
        state_n      = state;
        tx_valid_n   = tx_valid && !tx_ready;
        tx_data_n    = tx_data;
        count_n      = count;
        rep_n        = rep;
        dcol_n       = dcol;
        wcol_n       = wcol;
        row_n        = row;
        wdata_n      = wdata;
        wr_pulse_n   = 1'b0;
        eol_hi_n     = eol_hi;
        lead_n       = lead;
        dump_after_n = dump_after;
        resp_n       = resp;
        send         = 1'b0;
        send_byte    = '0;
        start_dump   = 1'b0;
        line_done    = 1'b0;
        acc          = 21'(count) * 21'd10 + 21'(rx_data[3:0]);

        // Every write strobe commits the current row and moves to the next
        // one; clear and cell writes both rely on this single advance.
        if (grid_wr_en)
            row_n = next_row;

        case (state)
            IDLE: begin
                if (rx_valid && rx_ready) begin
                    count_n = '0;
                    if (rx_data >= "0" && rx_data <= "9") begin
                        count_n   = (acc > MAX_ACC) ? MAX_CNT : acc[15:0];
                        send      = 1'b1;
                        send_byte = rx_data;
                    end else begin
                        case (rx_data)
                            "s": begin
                                rep_n        = (count == '0) ? 16'd1 : count;
                                dump_after_n = 1'b0;
                                state_n      = STEP;
                            end
                            "R": begin
                                rep_n        = 16'd1;
                                dump_after_n = 1'b1;
                                state_n      = STEP;
                            end
                            "r": start_dump = 1'b1;
                            "w": begin
                                row_n     = '0;
                                wcol_n    = '0;
                                send      = 1'b1;
                                send_byte = "W";
                            end
                            ".", "#": begin
                                send          = 1'b1;
                                send_byte     = rx_data;
                                wdata_n[wcol] = (rx_data == "#");
                                // The strobe lands next cycle with the full
                                // word; the row advances after that strobe.
                                if (wcol == LAST_COL) begin
                                    wr_pulse_n = 1'b1;
                                    wcol_n     = '0;
                                end else begin
                                    wcol_n = wcol + 1'b1;
                                end
                            end
                            "c": begin
                                wdata_n = '0;
                                row_n   = '0;
                                state_n = CLEAR;
                            end
                            default: begin
                                send      = 1'b1;
                                send_byte = "X";
                            end
                        endcase
                    end
                end
            end
            STEP: begin
                rep_n = rep - 1'b1;
                if (rep == 16'd1) begin
                    if (dump_after) begin
                        start_dump = 1'b1;
                    end else begin
                        resp_n  = "S";
                        state_n = ECHO;
                    end
                end
            end
            CLEAR: begin
                if (row == LAST_ROW) begin
                    wcol_n  = '0;
                    resp_n  = "C";
                    state_n = ECHO;
                end
            end
            ECHO: begin
                if (tx_free) begin
                    send      = 1'b1;
                    send_byte = resp;
                    state_n   = IDLE;
                end
            end
            DUMP_WAIT: begin
                dcol_n  = '0;
                state_n = DUMP_COL;
            end
            DUMP_COL: begin
                if (tx_free) begin
                    send      = 1'b1;
                    send_byte = grid_rd_data[dcol] ? "#" : ".";
                    if (dcol == LAST_COL) begin
                        eol_hi_n = 1'b0;
                        state_n  = DUMP_EOL;
                    end else begin
                        dcol_n = dcol + 1'b1;
                    end
                end
            end
            DUMP_EOL: begin
                if (tx_free) begin
                    send = 1'b1;
`ifdef GRID_BRIDGE_CRLF_EN
                    if (!eol_hi) begin
                        send_byte = 8'h0D;
                        eol_hi_n  = 1'b1;
                    end else begin
                        send_byte = 8'h0A;
                        eol_hi_n  = 1'b0;
                        line_done = 1'b1;
                    end
`else
                    send_byte = 8'h0A;
                    line_done = 1'b1;
`endif
                end
            end
            default: state_n = IDLE;
        endcase

        // A finished line is either the leading line end of a dump or the
        // end of a row; only the latter moves the row pointer.
        if (line_done) begin
            if (lead) begin
                lead_n  = 1'b0;
                state_n = DUMP_WAIT;
            end else if (row == LAST_ROW) begin
                row_n   = '0;
                state_n = IDLE;
            end else begin
                row_n   = next_row;
                state_n = DUMP_WAIT;
            end
        end

        if (start_dump) begin
            row_n    = '0;
            dcol_n   = '0;
            eol_hi_n = 1'b0;
`ifdef GRID_BRIDGE_CRLF_EN
            lead_n   = 1'b1;
            state_n  = DUMP_EOL;
`else
            lead_n   = 1'b0;
            state_n  = DUMP_WAIT;
`endif
        end

        if (send) begin
            tx_valid_n = 1'b1;
            tx_data_n  = send_byte;
        end
    end

endmodule

// File: tb/tb_uart_grid_bridge.sv
// Self-checking bench for uart_grid_bridge (COLS=8, ROWS=4, MAX_REPEAT=255).
// A command-level model predicts the transmitted byte stream, step burst
// lengths and row writes; a negedge monitor compares the DUT against it.
module tb_uart_grid_bridge;

    localparam int COLS = 8;
    localparam int ROWS = 4;
    localparam int MAXR = 255;
`ifdef GRID_BRIDGE_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif
    localparam int LEAD = CRLF ? 2 : 0;
    localparam int EOLN = CRLF ? 2 : 1;

    typedef struct {
        logic [1:0] row;
        logic [7:0] data;
    } wr_t;

    logic       clk, rst;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [1:0] grid_row_sel;
    logic       grid_step, grid_wr_en;
    logic [7:0] grid_wr_data, grid_rd_data;
    logic       busy;

    uart_grid_bridge #(.COLS(COLS), .ROWS(ROWS), .MAX_REPEAT(MAXR)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .grid_row_sel(grid_row_sel), .grid_step(grid_step),
        .grid_wr_en(grid_wr_en), .grid_wr_data(grid_wr_data),
        .grid_rd_data(grid_rd_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fake grid memory with one cycle read latency.
    logic [7:0] mem [ROWS];
    logic       preload;
    logic [7:0] preload_val;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < ROWS; i++) mem[i] <= preload_val;
        end else if (grid_wr_en) begin
            mem[grid_row_sel] <= grid_wr_data;
        end
        grid_rd_data <= mem[grid_row_sel];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Command-level model
    int         m_count, m_row, m_col;
    logic [7:0] m_word;
    logic [7:0] m_grid [ROWS];
    logic [7:0] tx_q[$];
    int         run_q[$];
    wr_t        wr_q[$];
    logic [7:0] tx_log[$];

    task automatic push_eol();
        if (CRLF) tx_q.push_back(8'h0D);
        tx_q.push_back(8'h0A);
    endtask

    task automatic model_dump();
        if (CRLF) push_eol();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) tx_q.push_back(m_grid[r][c] ? "#" : ".");
            push_eol();
        end
        m_row = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        wr_t w;
        if (b >= "0" && b <= "9") begin
            m_count = m_count * 10 + int'(b - "0");
            if (m_count > MAXR) m_count = MAXR;
            tx_q.push_back(b);
        end else begin
            case (b)
                "s": begin
                    run_q.push_back(m_count == 0 ? 1 : m_count);
                    tx_q.push_back("S");
                end
                "R": begin
                    run_q.push_back(1);
                    model_dump();
                end
                "r": model_dump();
                "w": begin
                    m_row = 0;
                    m_col = 0;
                    tx_q.push_back("W");
                end
                ".", "#": begin
                    tx_q.push_back(b);
                    m_word[m_col] = (b == "#");
                    if (m_col == COLS - 1) begin
                        w.row = 2'(m_row);
                        w.data = m_word;
                        wr_q.push_back(w);
                        m_grid[m_row] = m_word;
                        m_row = (m_row + 1) % ROWS;
                        m_col = 0;
                    end else begin
                        m_col++;
                    end
                end
                "c": begin
                    for (int r = 0; r < ROWS; r++) begin
                        w.row = 2'(r);
                        w.data = '0;
                        wr_q.push_back(w);
                        m_grid[r] = '0;
                    end
                    m_word = '0;
                    m_row = 0;
                    m_col = 0;
                    tx_q.push_back("C");
                end
                default: tx_q.push_back("X");
            endcase
            m_count = 0;
        end
    endtask

    // Monitor: compares the DUT against the model every cycle.
    int         run_len = 0;
    int         last_run = 0;
    int         wr_count = 0;
    int         last_wr_row = 0;
    logic [7:0] last_wr_data = '0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = '0;
    logic [7:0] exp_b;
    int         exp_run;
    wr_t        exp_w;

    always @(negedge clk) begin
        if (rst) begin
            run_len = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check(tx_valid === 1'b1 && tx_data === stall_data, "tx_hold",
                      32'(tx_data), 32'(stall_data));
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;

            if (tx_valid && tx_ready) begin
                tx_log.push_back(tx_data);
                check(tx_q.size() > 0, "tx_unexpected", 32'(tx_data), 0);
                if (tx_q.size() > 0) begin
                    exp_b = tx_q.pop_front();
                    check(tx_data === exp_b, "tx_byte", 32'(tx_data), 32'(exp_b));
                end
            end

            if (grid_step || grid_wr_en)
                check(!(grid_step && grid_wr_en), "step_wr_overlap", 1, 0);

            if (grid_step) begin
                run_len++;
            end else if (run_len > 0) begin
                last_run = run_len;
                check(run_q.size() > 0, "step_run_unexpected", run_len, 0);
                if (run_q.size() > 0) begin
                    exp_run = run_q.pop_front();
                    check(run_len == exp_run, "step_run_len", run_len, exp_run);
                end
                run_len = 0;
            end

            if (grid_wr_en) begin
                wr_count++;
                last_wr_row = int'(grid_row_sel);
                last_wr_data = grid_wr_data;
                check(wr_q.size() > 0, "wr_unexpected", 32'(grid_wr_data), 0);
                if (wr_q.size() > 0) begin
                    exp_w = wr_q.pop_front();
                    check(grid_row_sel === exp_w.row && grid_wr_data === exp_w.data, "wr_row_data",
                          32'({grid_row_sel, grid_wr_data}), 32'({exp_w.row, exp_w.data}));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int  n;
        bit  ok;
        n = 0;
        ok = 1'b0;
        rx_data = b;
        rx_valid = 1'b1;
        while (!ok && n < 500) begin
            @(negedge clk);
            if (rx_ready) ok = 1'b1;
            n++;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check(ok, "rx_accept_timeout", n, 500);
        if (ok) model_byte(b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || tx_valid || tx_q.size() != 0) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(n < 5000, "idle_timeout", n, 5000);
        repeat (2) @(posedge clk);
        #1;
        check(run_q.size() == 0, "step_runs_missing", run_q.size(), 0);
        check(wr_q.size() == 0, "writes_missing", wr_q.size(), 0);
    endtask

    task automatic model_reset();
        tx_q.delete();
        run_q.delete();
        wr_q.delete();
        m_count = 0;
        m_row = 0;
        m_col = 0;
        m_word = '0;
    endtask

    string pat;
    int    n_wait;

    initial begin
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = '0;
        tx_ready = 1'b1;
        preload = 1'b1;
        preload_val = '0;
        model_reset();
        for (int r = 0; r < ROWS; r++) m_grid[r] = '0;
        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        check(tx_valid === 1'b0, "rst_tx_valid", 32'(tx_valid), 0);
        check(tx_data === 8'h00, "rst_tx_data", 32'(tx_data), 0);
        check(grid_step === 1'b0, "rst_grid_step", 32'(grid_step), 0);
        check(grid_wr_en === 1'b0, "rst_grid_wr_en", 32'(grid_wr_en), 0);
        check(grid_wr_data === 8'h00, "rst_grid_wr_data", 32'(grid_wr_data), 0);
        check(grid_row_sel === 2'd0, "rst_grid_row_sel", 32'(grid_row_sel), 0);
        check(busy === 1'b0, "rst_busy", 32'(busy), 0);
        check(rx_ready === 1'b1, "rst_rx_ready", 32'(rx_ready), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Repeat count and step bursts
        tx_log.delete();
        send_str("12s");
        wait_idle();
        check(last_run == 12, "lit_run_12", last_run, 12);
        check(tx_log.size() == 3, "lit_12s_len", tx_log.size(), 3);
        if (tx_log.size() == 3)
            check(tx_log[0] == "1" && tx_log[1] == "2" && tx_log[2] == "S", "lit_12s_bytes",
                  32'({tx_log[0], tx_log[1], tx_log[2]}), 32'h3132_53);
        send_str("999s");
        wait_idle();
        check(last_run == 255, "lit_run_sat", last_run, 255);
        send_str("5x");
        send_str("s");
        wait_idle();
        check(last_run == 1, "lit_run_cleared", last_run, 1);
        send_str("0s");
        wait_idle();
        check(last_run == 1, "lit_run_zero", last_run, 1);

        // Row writes
        send_str("w#......#");
        wait_idle();
        check(last_wr_data == 8'h81, "lit_wr_data", 32'(last_wr_data), 32'h81);
        check(last_wr_row == 0, "lit_wr_row", last_wr_row, 0);
        check(grid_row_sel === 2'd1, "lit_row_adv", 32'(grid_row_sel), 1);
        send_str("##.......#.#.#.#########");
        wait_idle();
        check(grid_row_sel === 2'd0, "lit_row_wrap", 32'(grid_row_sel), 0);
        check(last_wr_data == 8'hFF && last_wr_row == 3, "lit_last_row",
              32'({last_wr_row[7:0], last_wr_data}), 32'h03FF);

        // Step then dump of the written rows
        send_str("R");
        wait_idle();
        check(last_run == 1, "lit_R_step", last_run, 1);

        // Dump of a known pattern
        preload_val = 8'h0F;
        preload = 1'b1;
        @(posedge clk);
        #1;
        preload = 1'b0;
        for (int r = 0; r < ROWS; r++) m_grid[r] = 8'h0F;
        tx_log.delete();
        send_str("r");
        wait_idle();
        check(tx_log.size() == LEAD + ROWS * (COLS + EOLN), "lit_dump_len",
              tx_log.size(), LEAD + ROWS * (COLS + EOLN));
        pat = "####....";
        if (tx_log.size() > LEAD + COLS) begin
            if (CRLF) check(tx_log[0] == 8'h0D && tx_log[1] == 8'h0A, "lit_dump_lead",
                            32'({tx_log[0], tx_log[1]}), 32'h0D0A);
            for (int i = 0; i < COLS; i++)
                check(tx_log[LEAD + i] == pat[i], "lit_dump_row0", 32'(tx_log[LEAD + i]), 32'(pat[i]));
            check(tx_log[LEAD + COLS + EOLN - 1] == 8'h0A, "lit_dump_eol",
                  32'(tx_log[LEAD + COLS + EOLN - 1]), 32'h0A);
        end
        check(grid_row_sel === 2'd0, "lit_dump_row_end", 32'(grid_row_sel), 0);

        // Transmitter stall during a dump
        send_str("r");
        repeat (10) @(posedge clk);
        #1;
        tx_ready = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        tx_ready = 1'b1;
        wait_idle();

        // Clear, with a byte offered while it runs
        wr_count = 0;
        tx_log.delete();
        send_str("c");
        rx_data = "q";
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        wait_idle();
        check(wr_count == 4, "lit_clear_count", wr_count, 4);
        check(last_wr_row == 3 && last_wr_data == 8'h00, "lit_clear_last",
              32'({last_wr_row[7:0], last_wr_data}), 32'h0300);
        check(tx_log.size() == 1, "lit_clear_tx_len", tx_log.size(), 1);
        if (tx_log.size() == 1) check(tx_log[0] == "C", "lit_clear_tx", 32'(tx_log[0]), 32'h43);
        check(grid_row_sel === 2'd0, "lit_clear_row", 32'(grid_row_sel), 0);

        // Reset in the middle of a dump
        send_str("r");
        n_wait = 0;
        while (grid_row_sel !== 2'd2 && n_wait < 1000) begin
            @(posedge clk);
            #1;
            n_wait++;
        end
        check(n_wait < 1000, "dump_row2_timeout", n_wait, 1000);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check(tx_valid === 1'b0, "midrst_tx_valid", 32'(tx_valid), 0);
        check(busy === 1'b0, "midrst_busy", 32'(busy), 0);
        rst = 1'b0;
        tx_log.delete();
        repeat (20) @(posedge clk);
        #1;
        check(tx_log.size() == 0, "midrst_quiet", tx_log.size(), 0);
        send_str("q");
        wait_idle();
        check(tx_log.size() == 1, "lit_q_len", tx_log.size(), 1);
        if (tx_log.size() == 1) check(tx_log[0] == "X", "lit_q_X", 32'(tx_log[0]), 32'h58);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
